// File: rtl/aud_stream_ctrl.sv
// Audio-domain sequencer: feeds codec samples to the input FIFO, plays equalised
// samples from the output FIFO with priming/underrun gating and block exponent shift.
module aud_stream_ctrl #(
  parameter int DW          = 16,
  parameter int BLOCK_LEN   = 8192,
  parameter int PRIME_LEVEL = 4096,
  parameter int CW          = 14
) (
  input  logic                 aud_clk,
  input  logic                 reset,
  input  logic                 chan_end,
  input  logic                 chan_req,
  input  logic                 in_fifo_wrfull,
  output logic                 in_fifo_wrreq,
  input  logic [CW-1:0]        out_fifo_rdusedw,
  input  logic [DW-1:0]        out_fifo_q,
  output logic                 out_fifo_rdreq,
  input  logic                 exp_update,
  input  logic signed [6:0]    exp_value,
  output logic [DW-1:0]        audio_output,
  output logic                 playing,
  output logic [15:0]          overrun_cnt,
  output logic [15:0]          underrun_cnt
);
  localparam int BW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

  typedef enum logic [1:0] {PRIME, PLAY, UNDERRUN} state_t;

  state_t            state_q, state_d;
  logic              end_r_q, req_r_q;
  logic              wrreq_q, wrreq_d;
  logic              rdreq_q, rdreq_d;
  logic [DW-1:0]     audio_q, audio_d;
  logic [15:0]       ovr_q, ovr_d, und_q, und_d;
  logic [BW-1:0]     blk_q, blk_d;
  logic signed [6:0] act_q, act_d, pend_q, pend_d;
  logic              pflag_q, pflag_d;
  logic              started_q, started_d;
  logic              end_ev, req_ev, rd, wrap, apply;

  // Right shift 1..12 is arithmetic; left shift -15..-1 preserves the sign bit.
  function automatic logic [DW-1:0] exp_shift(input logic [DW-1:0] x,
                                              input logic signed [6:0] e);
    logic [DW-1:0]     r;
    logic signed [6:0] ne;
    r  = '0;
    ne = -e;
    if (e == 7'sd0)
      r = x;
    else if (e > 7'sd0 && e <= 7'sd12)
      r = $unsigned($signed(x) >>> e[3:0]);
    else if (e < 7'sd0 && e >= -7'sd15)
      r = {x[DW-1], x[DW-2:0] << ne[3:0]};
    return r;
  endfunction

  assign end_ev = chan_end & ~end_r_q;
  assign req_ev = chan_req & ~req_r_q;

  always_comb begin
    state_d   = state_q;
    wrreq_d   = end_ev & ~in_fifo_wrfull;
    rdreq_d   = 1'b0;
    audio_d   = audio_q;
    ovr_d     = ovr_q;
    und_d     = und_q;
    blk_d     = blk_q;
    act_d     = act_q;
    pend_d    = pend_q;
    pflag_d   = pflag_q;
    started_d = started_q;
    rd        = 1'b0;

    if (end_ev && in_fifo_wrfull && ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;

    case (state_q)
      PLAY: begin
        if (req_ev) begin
          if (out_fifo_rdusedw != '0) begin
            rd      = 1'b1;
            rdreq_d = 1'b1;
            audio_d = exp_shift(out_fifo_q, act_q);
          end else begin
            audio_d = '0;
            state_d = UNDERRUN;
            if (und_q != 16'hFFFF) und_d = und_q + 16'd1;
          end
        end
      end
      default: begin
        if (req_ev) audio_d = '0;
        if (out_fifo_rdusedw >= CW'(PRIME_LEVEL)) state_d = PLAY;
      end
    endcase

    wrap  = rd && (blk_q == BW'(BLOCK_LEN - 1));
    // Before the first read the pending exponent tracks straight into the active one.
    apply = wrap || !started_q;

    if (rd) begin
      started_d = 1'b1;
      blk_d     = wrap ? '0 : blk_q + BW'(1);
    end

    if (apply && (pflag_q || !started_q)) begin
      act_d   = pend_q;
      pflag_d = 1'b0;
    end

    // An update colliding with a wrap is held for the following boundary.
    if (exp_update) begin
      pend_d  = exp_value;
      pflag_d = 1'b1;
    end
  end

  always_ff @(posedge aud_clk) begin
    if (reset) begin
      state_q   <= PRIME;
      end_r_q   <= 1'b0;
      req_r_q   <= 1'b0;
      wrreq_q   <= 1'b0;
      rdreq_q   <= 1'b0;
      audio_q   <= '0;
      ovr_q     <= '0;
      und_q     <= '0;
      blk_q     <= '0;
      act_q     <= '0;
      pend_q    <= '0;
      pflag_q   <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      end_r_q   <= chan_end;
      req_r_q   <= chan_req;
      wrreq_q   <= wrreq_d;
      rdreq_q   <= rdreq_d;
      audio_q   <= audio_d;
      ovr_q     <= ovr_d;
      und_q     <= und_d;
      blk_q     <= blk_d;
      act_q     <= act_d;
      pend_q    <= pend_d;
      pflag_q   <= pflag_d;
      started_q <= started_d;
    end
  end

  assign in_fifo_wrreq  = wrreq_q;
  assign out_fifo_rdreq = rdreq_q;
  assign audio_output   = audio_q;
  assign playing        = (state_q == PLAY);
  assign overrun_cnt    = ovr_q;
  assign underrun_cnt   = und_q;
endmodule

// File: doc/aud_stream_ctrl.md
Name: aud_stream_ctrl

Overview:
Audio-clock-domain sequencer for the audio-to-FFT datapath. It writes codec samples into the input dual-clock FIFO and reads equalised samples from the output FIFO. It gates playback until enough output is buffered and applies the combined FFT block exponent at block boundaries. It also counts overrun and underrun events for the CPU.

Parameters:
DW, 16, sample width (bits)
BLOCK_LEN, 8192, samples per FFT block (exponent update boundary)
PRIME_LEVEL, 4096, output-FIFO words required before entering or resuming playback
CW, 14, width of out_fifo_rdusedw

Ports:
aud_clk  in  1  audio clock; all logic on rising edge
reset  in  1  synchronous, active-high
chan_end  in  1  codec: new input sample valid on audio_input (level; rising edge = event)
chan_req  in  1  codec: request output sample (level; rising edge = event)
in_fifo_wrfull  in  1  input FIFO full (write side)
in_fifo_wrreq  out  1  input FIFO write strobe
out_fifo_rdusedw  in  CW  output FIFO fill level (read side)
out_fifo_q  in  DW  output FIFO show-ahead data
out_fifo_rdreq  out  1  output FIFO read acknowledge
exp_update  in  1  one-cycle pulse: new block exponent on exp_value (already synchronised)
exp_value  in  7  signed combined exponent, range -15..+12 meaningful
audio_output  out  DW  sample to codec
playing  out  1  high in PLAY state
overrun_cnt  out  16  input samples dropped because FIFO full
underrun_cnt  out  16  PLAY-to-UNDERRUN transitions

Behaviour:
- Reset (synchronous, aud_clk):
  - Outputs: in_fifo_wrreq=0, out_fifo_rdreq=0, audio_output=0, playing=0, both counters=0.
  - Internal: state=PRIME, active_exp=0, pending_exp=0, pending_flag=0, blk_cnt=0, edge registers=0.
  - Reset mid-block discards the pending exponent and the block position.
- Edge detect: chan_end_r and chan_req_r are registered. An event is a rising edge (cur & ~prev). A held-high level produces a single event.
- Input path: a chan_end event with wrfull=0 asserts in_fifo_wrreq for exactly the next cycle (latency 1). With wrfull=1 there is no write, and overrun_cnt increments, saturating at 0xFFFF.
- State machine:
  - PRIME: on chan_req, drive audio_output=0 and no rdreq. Go to PLAY when rdusedw >= PRIME_LEVEL.
  - PLAY: on chan_req with rdusedw > 0, pulse out_fifo_rdreq for 1 cycle and set audio_output = shift(out_fifo_q, active_exp), registered in the same cycle the rdreq asserts. On chan_req with rdusedw == 0, set audio_output=0, go to UNDERRUN, and increment underrun_cnt (saturating).
  - UNDERRUN: behaves as PRIME. Return to PLAY at rdusedw >= PRIME_LEVEL.
  - playing=1 only in PLAY.
- audio_output holds its value between chan_req events.
- Block/exponent:
  - blk_cnt counts successful reads 0..BLOCK_LEN-1 and wraps to 0.
  - exp_update loads pending_exp and sets pending_flag. A second update before it is applied overwrites pending_exp.
  - When a read makes blk_cnt wrap, or when blk_cnt==0 and no read has yet occurred since reset, pending_exp is copied to active_exp and pending_flag is cleared.
  - The new exponent applies to the first sample of the next block, not the sample that wrapped.
  - Simultaneous exp_update and wrap: the incoming value goes to pending and is applied at the following wrap; the old pending value is applied now.
- Shift function (x = out_fifo_q, e = active_exp):
  - e=0: output x.
  - 1 <= e <= 12: arithmetic right shift by e (sign-extended).
  - -15 <= e <= -1: left shift by k=-e keeping sign bit: {x[15], x[14-k:0], k zeros}.
  - Any other e: output 0.
- Simultaneous chan_end and chan_req events are independent and both are serviced in the same cycle.

Test Plan:
- Reset, then 5 chan_end pulses with wrfull=0 -> 5 single-cycle wrreq pulses, each 1 cycle after the edge; overrun_cnt=0. Hold chan_end high 10 cycles -> exactly 1 wrreq.
- wrfull=1 with 3 chan_end events -> no wrreq, overrun_cnt=3.
- rdusedw=4095 with chan_req events -> audio_output=0, no rdreq, playing=0. Set rdusedw=4096 -> playing=1; next chan_req with q=0x1234, exp=0 -> rdreq pulse, audio_output=0x1234.
- In PLAY, rdusedw=0 on chan_req -> audio_output=0, underrun_cnt=1, playing=0. Refill to 4096 -> PLAY resumes.
- Shift checks, q=0x8000: exp=+3 -> 0xF000. q=0x0123, exp=-4 -> 0x1230. exp=+13 -> 0x0000. exp=-15, q=0xFFFF -> 0x8000.
- exp_update(+2) at blk_cnt=100 -> samples up to index 8191 use old exponent; sample 8192 (next block's first) is shifted by 2. Reset asserted at blk_cnt=500 -> blk_cnt=0, active_exp=0, PRIME.
